// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage in front of the combinational ALU.
// Decodes a 16-bit instruction, picks operands from the register file (with
// optional forwarding of the ALU result being written back this cycle), and
// presents one registered bundle to the ALU. Also owns the PSR.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   fetch-side handshake; in_inst, in_pc instruction + address
//   rf_raddr_a/b        combinational RF read addresses; rf_rdata_a/b read data
//   out_valid/out_ready ALU-side handshake; out_* registered bundle
//   cond_in             PSR {C,L,F,Z,N} presented to the ALU
//   alu_result          ALU result (forwarding source)
//   alu_condOut/condWr  PSR update from the ALU, applied at fire
module alu_issue_stage #(
  parameter logic [4:0]  PSR_RESET = 5'b00000,
  parameter int unsigned FWD_EN    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_inst,
  input  logic [15:0] in_pc,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_oper,
  output logic [3:0]  out_func,
  output logic [3:0]  out_cond,
  output logic [15:0] out_dst,
  output logic [15:0] out_src,
  output logic [4:0]  cond_in,
  output logic        out_wr_en,
  output logic [3:0]  out_wr_addr,
  output logic        out_pc_wr,
  output logic        out_illegal,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_condOut,
  input  logic        alu_condWr
);

  localparam int unsigned DW = 16;

  localparam logic [3:0] OP_REG     = 4'h0;
  localparam logic [3:0] OP_ANDI    = 4'h1;
  localparam logic [3:0] OP_ORI     = 4'h2;
  localparam logic [3:0] OP_XORI    = 4'h3;
  localparam logic [3:0] OP_SPECIAL = 4'h4;
  localparam logic [3:0] OP_SHIFT   = 4'h8;
  localparam logic [3:0] OP_CMPI    = 4'hB;
  localparam logic [3:0] OP_BCOND   = 4'hC;
  localparam logic [3:0] OP_MOVI    = 4'hD;
  localparam logic [3:0] OP_LUI     = 4'hF;

  localparam logic [3:0] SP_JCOND   = 4'hC;
  localparam logic [3:0] SP_SCOND   = 4'hD;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_oper_q, out_oper_d;
  logic [3:0]  out_func_q, out_func_d;
  logic [3:0]  out_cond_q, out_cond_d;
  logic [15:0] out_dst_q, out_dst_d;
  logic [15:0] out_src_q, out_src_d;
  logic        out_wr_en_q, out_wr_en_d;
  logic [3:0]  out_wr_addr_q, out_wr_addr_d;
  logic        out_pc_wr_q, out_pc_wr_d;
  logic        out_illegal_q, out_illegal_d;
  logic [4:0]  psr_q, psr_d;

  logic        accept, fire;
  logic        fwd_on;
  logic [3:0]  f_oper, f_rdest, f_func, f_rsrc;
  logic [15:0] opa, opb, imm_sx, imm_zx, sh_amt;
  logic [3:0]  dec_func, dec_cond, dec_wr_addr;
  logic [15:0] dec_dst, dec_src;
  logic        dec_wr_en, dec_pc_wr, dec_ill;

  assign f_oper  = in_inst[15:12];
  assign f_rdest = in_inst[11:8];
  assign f_func  = in_inst[7:4];
  assign f_rsrc  = in_inst[3:0];

  assign rf_raddr_a = f_rdest;
  assign rf_raddr_b = f_rsrc;

  assign fire     = out_valid_q & out_ready;
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // The bundle leaving now writes the RF at this edge; the RF read is stale.
  assign fwd_on = (FWD_EN != 0) && accept && fire && out_wr_en_q;
  assign opa    = (fwd_on && (out_wr_addr_q == f_rdest)) ? alu_result : rf_rdata_a;
  assign opb    = (fwd_on && (out_wr_addr_q == f_rsrc))  ? alu_result : rf_rdata_b;

  assign imm_sx = {{8{in_inst[7]}}, in_inst[7:0]};
  assign imm_zx = {8'h00, in_inst[7:0]};
  assign sh_amt = {12'h000, f_rsrc};

  // Instruction decode and operand selection
  always_comb begin
    dec_func    = 4'h0;
    dec_cond    = 4'h0;
    dec_dst     = opa;
    dec_src     = opb;
    dec_wr_en   = 1'b1;
    dec_wr_addr = f_rdest;
    dec_pc_wr   = 1'b0;
    dec_ill     = 1'b0;
    case (f_oper)
      OP_REG: begin
        dec_func = f_func;
        case (f_func)
          4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
          4'h9, 4'hA, 4'hD, 4'hE: dec_wr_en = 1'b1;
          4'h8, 4'hB:             dec_wr_en = 1'b0;  // TEST, CMP
          default:                dec_ill   = 1'b1;
        endcase
      end
      OP_SHIFT: begin
        dec_func = f_func;
        case (f_func)
          4'h0, 4'h2: dec_src = sh_amt;                    // immediate left
          4'h1, 4'h3: dec_src = DW'(16'h0000 - sh_amt);    // immediate right as negative count
          4'h4, 4'h6: dec_src = opb;                       // register count
          default:    dec_ill = 1'b1;
        endcase
      end
      OP_SPECIAL: begin
        dec_func = f_func;
        case (f_func)
          SP_JCOND: begin
            dec_cond  = f_rdest;
            dec_dst   = in_pc;
            dec_src   = opb;
            dec_pc_wr = 1'b1;
            dec_wr_en = 1'b0;
          end
          SP_SCOND: begin
            dec_cond    = f_rdest;
            dec_dst     = 16'h0000;
            dec_src     = 16'h0000;
            dec_wr_addr = f_rsrc;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_BCOND: begin
        dec_cond  = f_rdest;
        dec_dst   = in_pc;
        dec_src   = imm_sx;
        dec_pc_wr = 1'b1;
        dec_wr_en = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI: dec_src = imm_zx;
      OP_CMPI: begin
        dec_src   = imm_sx;
        dec_wr_en = 1'b0;
      end
      default: dec_src = imm_sx;  // ADDI/ADDUI/ADDCI/SUBI/SUBCI/MULI
    endcase
    if (dec_ill) begin
      dec_cond  = 4'h0;
      dec_dst   = 16'h0000;
      dec_src   = 16'h0000;
      dec_wr_en = 1'b0;
      dec_pc_wr = 1'b0;
    end
  end

  // Bundle / PSR next state
  always_comb begin
    out_valid_d   = out_valid_q;
    out_oper_d    = out_oper_q;
    out_func_d    = out_func_q;
    out_cond_d    = out_cond_q;
    out_dst_d     = out_dst_q;
    out_src_d     = out_src_q;
    out_wr_en_d   = out_wr_en_q;
    out_wr_addr_d = out_wr_addr_q;
    out_pc_wr_d   = out_pc_wr_q;
    out_illegal_d = out_illegal_q;
    psr_d         = psr_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_oper_d    = f_oper;
      out_func_d    = dec_func;
      out_cond_d    = dec_cond;
      out_dst_d     = dec_dst;
      out_src_d     = dec_src;
      out_wr_en_d   = dec_wr_en;
      out_wr_addr_d = dec_wr_addr;
      out_pc_wr_d   = dec_pc_wr;
      out_illegal_d = dec_ill;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
    if (fire && alu_condWr) psr_d = alu_condOut;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_oper_q    <= 4'h0;
      out_func_q    <= 4'h0;
      out_cond_q    <= 4'h0;
      out_dst_q     <= 16'h0000;
      out_src_q     <= 16'h0000;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= 4'h0;
      out_pc_wr_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      psr_q         <= PSR_RESET;
    end else begin
      out_valid_q   <= out_valid_d;
      out_oper_q    <= out_oper_d;
      out_func_q    <= out_func_d;
      out_cond_q    <= out_cond_d;
      out_dst_q     <= out_dst_d;
      out_src_q     <= out_src_d;
      out_wr_en_q   <= out_wr_en_d;
      out_wr_addr_q <= out_wr_addr_d;
      out_pc_wr_q   <= out_pc_wr_d;
      out_illegal_q <= out_illegal_d;
      psr_q         <= psr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_oper    = out_oper_q;
  assign out_func    = out_func_q;
  assign out_cond    = out_cond_q;
  assign out_dst     = out_dst_q;
  assign out_src     = out_src_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_wr_addr = out_wr_addr_q;
  assign out_pc_wr   = out_pc_wr_q;
  assign out_illegal = out_illegal_q;
  assign cond_in     = psr_q;

endmodule
